// File: rtl/seq_divider.sv
// Sequential signed restoring divider: 2W-bit dividend by W-bit divisor.
// Magnitudes are divided one quotient bit per clock; signs are applied at the end.
module seq_divider #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] Z,
    input  logic [W-1:0]   M,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           div_by_zero,
    output logic           overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_FIX
    } state_t;

    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0] LAST = CW'(2*W-1);
    localparam logic [2*W-1:0] HALF = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [2*W-1:0]   r_zmag;
    logic [W-1:0]     r_mmag;
    logic [W-1:0]     r_zlow;
    logic             r_zneg;
    logic             r_mneg;
    logic [W:0]       r_part;
    logic [2*W-1:0]   r_quo;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_r;
    logic             r_dbz;
    logic             r_ovf;

    logic [2*W-1:0]   w_zabs;
    logic [W-1:0]     w_mabs;
    logic [W+1:0]     w_shift;
    logic [W+1:0]     w_diff;
    logic             w_ge;
    logic             w_qneg;
    logic [W-1:0]     w_qlo;
    logic [W-1:0]     w_rlo;
    logic             w_ovf;
    logic             w_dbz;

    assign w_zabs  = Z[2*W-1] ? -Z : Z;
    assign w_mabs  = M[W-1] ? -M : M;

    // Partial remainder gains one dividend bit; the extra top bit flags a borrow.
    assign w_shift = {r_part, r_zmag[2*W-1]};
    assign w_diff  = w_shift - {2'b00, r_mmag};
    assign w_ge    = ~w_diff[W+1];

    assign w_qneg  = r_zneg ^ r_mneg;
    assign w_qlo   = w_qneg ? -r_quo[W-1:0] : r_quo[W-1:0];
    assign w_rlo   = r_zneg ? -r_part[W-1:0] : r_part[W-1:0];
    // A negative quotient may reach magnitude 2^(W-1); a positive one may not.
    assign w_ovf   = w_qneg ? (r_quo > HALF) : (r_quo >= HALF);
    assign w_dbz   = (r_mmag == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_zmag  <= '0;
            r_mmag  <= '0;
            r_zlow  <= '0;
            r_zneg  <= 1'b0;
            r_mneg  <= 1'b0;
            r_part  <= '0;
            r_quo   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_zmag  <= w_zabs;
                        r_mmag  <= w_mabs;
                        r_zlow  <= Z[W-1:0];
                        r_zneg  <= Z[2*W-1];
                        r_mneg  <= M[W-1];
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_part  <= '0;
                    r_quo   <= '0;
                    r_count <= '0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_zmag  <= {r_zmag[2*W-2:0], 1'b0};
                    r_part  <= w_ge ? w_diff[W:0] : w_shift[W:0];
                    r_quo   <= {r_quo[2*W-2:0], w_ge};
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (w_dbz) begin
                        r_q   <= '1;
                        r_r   <= r_zlow;
                        r_dbz <= 1'b1;
                        r_ovf <= 1'b0;
                    end else begin
                        r_q   <= w_qlo;
                        r_r   <= w_rlo;
                        r_dbz <= 1'b0;
                        r_ovf <= w_ovf;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases plus random operands
// checked against integer division from a reference model.
module tb_seq_divider;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*W-1:0] Z;
    logic [W-1:0]   M;
    logic           busy;
    logic           done;
    logic [W-1:0]   Q;
    logic [W-1:0]   R;
    logic           div_by_zero;
    logic           overflow;

    int total = 0;
    int bad   = 0;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Z           (Z),
        .M           (M),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: C/MIPS semantics via plain integer division.
    task automatic model(input logic [15:0] z, input logic [7:0] m,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
        int zi;
        int mi;
        int qi;
        int ri;
        logic [31:0] qv;
        logic [31:0] rv;
        zi = int'($signed(z));
        mi = int'($signed(m));
        if (mi == 0) begin
            q  = 8'hFF;
            r  = z[7:0];
            dz = 1'b1;
            ov = 1'b0;
        end else begin
            qi = zi / mi;
            ri = zi % mi;
            qv = qi;
            rv = ri;
            q  = qv[7:0];
            r  = rv[7:0];
            dz = 1'b0;
            ov = (qi > 127) || (qi < -128);
        end
    endtask

    task automatic start_op(input logic [15:0] z, input logic [7:0] m);
        @(negedge clk);
        Z = z;
        M = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        Z = 16'($urandom);
        M = 8'($urandom);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done) return;
            if (busy) nb++;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] z,
                             input logic [7:0] m);
        logic [7:0] eq;
        logic [7:0] er;
        logic edz;
        logic eov;
        model(z, m, eq, er, edz, eov);
        chk({tag, "_Q"}, Q, eq);
        chk({tag, "_R"}, R, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        chk({tag, "_ovf"}, overflow, eov);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] z,
                          input logic [7:0] m);
        int n;
        int nb;
        start_op(z, m);
        wait_done(n, nb);
        chk({tag, "_latency"}, n, 18);
        check_res(tag, z, m);
    endtask

    initial begin
        int n;
        int nb;
        int ndone;
        logic [15:0] rz;
        logic [7:0]  rm;
        int qi;
        int mi;
        logic [31:0] qv;

        rst = 1'b1;
        start = 1'b0;
        Z = '0;
        M = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_Q", Q, 8'h00);
        chk("rst_R", R, 8'h00);
        chk("rst_dbz", div_by_zero, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic operation with fixed expected values.
        start_op(16'd100, 8'd7);
        wait_done(n, nb);
        chk("t1_latency", n, 18);
        chk("t1_busy_cycles", 1 + nb, 18);
        chk("t1_Q", Q, 8'h0E);
        chk("t1_R", R, 8'h02);
        chk("t1_flags", {div_by_zero, overflow}, 2'b00);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_Q_hold", Q, 8'h0E);
        chk("t1_R_hold", R, 8'h02);

        // Sign combinations.
        start_op(16'hFF9C, 8'd7);
        wait_done(n, nb);
        chk("t2a_Q", Q, 8'hF2);
        chk("t2a_R", R, 8'hFE);
        run_op("t2b", 16'd100, 8'hF9);
        run_op("t2c", 16'hFF9C, 8'hF9);

        // Divide by zero.
        start_op(16'h1234, 8'h00);
        wait_done(n, nb);
        chk("t3_latency", n, 18);
        chk("t3_Q", Q, 8'hFF);
        chk("t3_R", R, 8'h34);
        chk("t3_dbz", div_by_zero, 1'b1);
        chk("t3_ovf", overflow, 1'b0);

        // Overflow boundaries.
        run_op("t4a", 16'hFF00, 8'h02);
        chk("t4a_Q_const", Q, 8'h80);
        run_op("t4b", 16'h0100, 8'h02);
        chk("t4b_ovf_const", overflow, 1'b1);
        run_op("t4c", 16'h8000, 8'hFF);
        chk("t4c_Q_const", Q, 8'h00);
        run_op("t4d", 16'h8000, 8'h80);
        run_op("t4e", 16'h7FFF, 8'h01);

        // Start during busy is ignored; start in the done cycle is taken.
        start_op(16'd100, 8'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        Z = 16'd5;
        M = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        chk("t5_ignored_latency", n, 15);
        check_res("t5_ignored", 16'd100, 8'd7);
        Z = 16'hFF9C;
        M = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        Z = 16'h0;
        M = 8'h0;
        chk("t5_done_cycle_accept", busy, 1'b1);
        wait_done(n, nb);
        chk("t5_back2back_latency", n, 18);
        check_res("t5_back2back", 16'hFF9C, 8'd7);

        // Reset in the middle of an operation.
        start_op(16'h1234, 8'd5);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        chk("t5_rst_Q", Q, 8'h00);
        chk("t5_rst_R", R, 8'h00);
        chk("t5_rst_dbz", div_by_zero, 1'b0);
        chk("t5_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("t5_rst_no_done", ndone, 0);

        // Random operands against the model.
        for (int i = 0; i < 40; i++) begin
            rz = 16'($urandom);
            rm = 8'($urandom);
            if (i % 10 == 0) rm = 8'h00;
            if (i % 10 == 1) rm = 8'h80;
            if (i % 10 == 2) rm = 8'hFF;
            run_op("rand", rz, rm);
        end

        // Round trip: Z = M*Q must come back exactly.
        for (int i = 0; i < 30; i++) begin
            rm = 8'($urandom_range(1, 255));
            mi = int'($signed(rm));
            qi = int'($urandom_range(0, 255)) - 128;
            rz = 16'(mi * qi);
            qv = qi;
            start_op(rz, rm);
            wait_done(n, nb);
            chk("rt_latency", n, 18);
            chk("rt_Q", Q, qv[7:0]);
            chk("rt_R", R, 8'h00);
            chk("rt_flags", {div_by_zero, overflow}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
